// File: rtl/host_frame_pkg.sv
// rtl/host_frame_pkg.sv - shared constants, FSM encoding and checksum helper for host_frame_receiver
// Optional feature macro: HOST_FRAME_CHECKSUM_EN
package host_frame_pkg;

  localparam int         FRAME_DATA_BYTES  = 4;
  localparam int         IDX_W             = $clog2(FRAME_DATA_BYTES);
  localparam int         TIMEOUT_W         = 32;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CTRL    = 3'd1,
    ST_DATA    = 3'd2,
`ifdef HOST_FRAME_CHECKSUM_EN
    ST_CHK     = 3'd3,
`endif
    ST_HOLD    = 3'd4,
    ST_RELEASE = 3'd5
  } state_e;

`ifdef HOST_FRAME_CHECKSUM_EN
  function automatic logic [7:0] frame_checksum(input logic [7:0] ctrl, input logic [31:0] data);
    return ctrl ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
  endfunction
`endif

endpackage

// File: rtl/frame_timeout_counter.sv
// rtl/frame_timeout_counter.sv - idle-cycle counter that flags expiry at limit-1
// Holds at the expiry value until cleared.
module frame_timeout_counter
  import host_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign expired = enable && (count_q == limit - TIMEOUT_W'(1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/host_frame_receiver.sv
// rtl/host_frame_receiver.sv - byte-stream frame receiver with hold/acknowledge handshake
// Optional feature macro: HOST_FRAME_CHECKSUM_EN (adds CHK state and trailing XOR checksum byte)
module host_frame_receiver
  import host_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        masterClock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxByte,
  input  logic        clearDR,
  output logic        dataReceived,
  output logic [7:0]  control,
  output logic [31:0] inputData,
  output logic        frameError,
  output logic        overrun
);

`ifdef HOST_FRAME_CHECKSUM_EN
  localparam int SH_W = 32;
`else
  // The last data byte goes straight to the output, so only three are shadowed.
  localparam int SH_W = 24;
`endif

  state_e            state_q, state_d;
  logic [7:0]        ctrl_sh_q, ctrl_sh_d;
  logic [SH_W-1:0]   data_sh_q, data_sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        control_q, control_d;
  logic [31:0]       input_data_q, input_data_d;
  logic              data_received_q, data_received_d;
  logic              frame_error_q, frame_error_d;
  logic              overrun_q, overrun_d;
  logic              in_frame, expired, timeout, last_idx, commit, chk_ok;
  logic [31:0]       commit_data;

  assign in_frame = (state_q == ST_CTRL) || (state_q == ST_DATA)
`ifdef HOST_FRAME_CHECKSUM_EN
                 || (state_q == ST_CHK)
`endif
                 ;
  assign timeout  = expired && !rxValid;
  assign last_idx = (idx_q == IDX_W'(FRAME_DATA_BYTES - 1));
`ifdef HOST_FRAME_CHECKSUM_EN
  assign chk_ok   = (rxByte == frame_checksum(ctrl_sh_q, data_sh_q));
`else
  assign chk_ok   = 1'b0;
`endif

  frame_timeout_counter u_timeout (
    .clk     (masterClock),
    .reset   (reset),
    .clear   (!in_frame || rxValid),
    .enable  (in_frame),
    .limit   (TIMEOUT_W'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  always_ff @(posedge masterClock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (rxValid && rxByte == SYNC_BYTE) state_d = ST_CTRL;
      ST_CTRL:    if (rxValid) state_d = ST_DATA; else if (timeout) state_d = ST_IDLE;
      ST_DATA: begin
        if (rxValid && last_idx) begin
`ifdef HOST_FRAME_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_HOLD;
`endif
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
`ifdef HOST_FRAME_CHECKSUM_EN
      ST_CHK:     if (rxValid) state_d = chk_ok ? ST_HOLD : ST_IDLE; else if (timeout) state_d = ST_IDLE;
`endif
      ST_HOLD:    if (clearDR) state_d = ST_RELEASE;
      ST_RELEASE: if (!clearDR) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_sh_d       = ctrl_sh_q;
    data_sh_d       = data_sh_q;
    idx_d           = idx_q;
    control_d       = control_q;
    input_data_d    = input_data_q;
    data_received_d = data_received_q;
    frame_error_d   = 1'b0;
    overrun_d       = 1'b0;
    commit          = 1'b0;
    commit_data     = 32'h0;
    case (state_q)
      ST_CTRL: if (rxValid) begin
        ctrl_sh_d = rxByte;
        idx_d     = '0;
      end
      ST_DATA: if (rxValid) begin
        data_sh_d = {data_sh_q[SH_W-9:0], rxByte};
        idx_d     = idx_q + IDX_W'(1);
`ifndef HOST_FRAME_CHECKSUM_EN
        commit      = last_idx;
        commit_data = {data_sh_q, rxByte};
`endif
      end
`ifdef HOST_FRAME_CHECKSUM_EN
      ST_CHK: if (rxValid) begin
        commit        = chk_ok;
        commit_data   = data_sh_q;
        frame_error_d = !chk_ok;
      end
`endif
      ST_HOLD: begin
        overrun_d = rxValid;
        if (clearDR) data_received_d = 1'b0;
      end
      ST_RELEASE: overrun_d = rxValid;
      default: ;
    endcase
    if (in_frame && timeout) frame_error_d = 1'b1;
    if (commit) begin
      control_d       = ctrl_sh_q;
      input_data_d    = commit_data;
      data_received_d = 1'b1;
    end
    if (commit || state_d == ST_IDLE) begin
      ctrl_sh_d = '0;
      data_sh_d = '0;
      idx_d     = '0;
    end
  end

  always_ff @(posedge masterClock) begin
    if (reset) begin
      ctrl_sh_q       <= '0;
      data_sh_q       <= '0;
      idx_q           <= '0;
      control_q       <= '0;
      input_data_q    <= '0;
      data_received_q <= 1'b0;
      frame_error_q   <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      ctrl_sh_q       <= ctrl_sh_d;
      data_sh_q       <= data_sh_d;
      idx_q           <= idx_d;
      control_q       <= control_d;
      input_data_q    <= input_data_d;
      data_received_q <= data_received_d;
      frame_error_q   <= frame_error_d;
      overrun_q       <= overrun_d;
    end
  end

  assign dataReceived = data_received_q;
  assign control      = control_q;
  assign inputData    = input_data_q;
  assign frameError   = frame_error_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_host_frame_receiver.sv
// tb/tb_host_frame_receiver.sv - directed self-checking bench for host_frame_receiver
// Honours HOST_FRAME_CHECKSUM_EN: frames then carry a trailing XOR checksum byte.
module tb_host_frame_receiver;

`ifdef HOST_FRAME_CHECKSUM_EN
  localparam int NBYTES = 7;
`else
  localparam int NBYTES = 6;
`endif

  logic        masterClock = 1'b0;
  logic        reset = 1'b1;
  logic        rxValid = 1'b0;
  logic [7:0]  rxByte = 8'h00;
  logic        clearDR = 1'b0;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        frameError;
  logic        overrun;

  int checks = 0;
  int fails  = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  host_frame_receiver #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
    .masterClock  (masterClock),
    .reset        (reset),
    .rxValid      (rxValid),
    .rxByte       (rxByte),
    .clearDR      (clearDR),
    .dataReceived (dataReceived),
    .control      (control),
    .inputData    (inputData),
    .frameError   (frameError),
    .overrun      (overrun)
  );

  always #5 masterClock = ~masterClock;

  task automatic tick();
    @(posedge masterClock);
    #1;
    if (frameError) fe_cnt++;
    if (overrun) ov_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxValid = 1'b1;
    rxByte  = b;
    tick();
    rxValid = 1'b0;
    rxByte  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
    send_byte(8'hA5);
    send_byte(c);
    for (int i = 0; i < 4; i++) send_byte(d[31-8*i -: 8]);
`ifdef HOST_FRAME_CHECKSUM_EN
    send_byte(c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
  endtask

  task automatic release_frame();
    clearDR = 1'b1;
    tick();
    clearDR = 1'b0;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    check("reset_dr",   32'(dataReceived), 32'h0);
    check("reset_ctrl", 32'(control),      32'h0);
    check("reset_data", inputData,         32'h0);
    check("reset_fe",   32'(frameError),   32'h0);
    check("reset_ov",   32'(overrun),      32'h0);

    fe_cnt = 0; ov_cnt = 0;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    check("junk_dr", 32'(dataReceived), 32'h0);
    send_frame(8'h01, 32'hDEADBEEF);
    check("f1_dr",        32'(dataReceived), 32'h1);
    check("f1_ctrl",      32'(control),      32'h01);
    check("f1_data",      inputData,         32'hDEADBEEF);
    check("junk_no_fe",   32'(fe_cnt),       32'h0);
    check("junk_no_ov",   32'(ov_cnt),       32'h0);

    clearDR = 1'b1;
    tick();
    check("clr_dr", 32'(dataReceived), 32'h0);
    ov_cnt = 0;
    send_frame(8'h02, 32'h00000005);
    check("ovr_count", 32'(ov_cnt),       32'(NBYTES));
    check("ovr_ctrl",  32'(control),      32'h01);
    check("ovr_data",  inputData,         32'hDEADBEEF);
    check("ovr_dr",    32'(dataReceived), 32'h0);
    clearDR = 1'b0;
    tick();
    send_frame(8'h02, 32'h00000005);
    check("f2_dr",   32'(dataReceived), 32'h1);
    check("f2_ctrl", 32'(control),      32'h02);
    check("f2_data", inputData,         32'h00000005);
    check("f2_ov",   32'(ov_cnt),       32'(NBYTES));
    release_frame();

    fe_cnt = 0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    repeat (15) tick();
    check("to_early", 32'(fe_cnt), 32'h0);
    tick();
    check("to_pulse", 32'(frameError), 32'h1);
    repeat (10) tick();
    check("to_single", 32'(fe_cnt),       32'h1);
    check("to_dr",     32'(dataReceived), 32'h0);
    check("to_ctrl",   32'(control),      32'h02);

    send_byte(8'hA5); send_byte(8'h03);
    repeat (15) tick();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
`ifdef HOST_FRAME_CHECKSUM_EN
    send_byte(8'h47);
`endif
    check("win_fe",   32'(fe_cnt),       32'h1);
    check("win_dr",   32'(dataReceived), 32'h1);
    check("win_ctrl", 32'(control),      32'h03);
    check("win_data", inputData,         32'h11223344);
    release_frame();

    send_byte(8'hA5); send_byte(8'h04); send_byte(8'hAA);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_ctrl", 32'(control),      32'h0);
    check("rmid_data", inputData,         32'h0);
    check("rmid_dr",   32'(dataReceived), 32'h0);
    send_frame(8'h05, 32'hCAFEF00D);
    check("rmid_f_ctrl", 32'(control), 32'h05);
    check("rmid_f_data", inputData,    32'hCAFEF00D);

    reset = 1'b1; rxValid = 1'b1; rxByte = 8'hA5;
    tick();
    reset = 1'b0; rxValid = 1'b0; rxByte = 8'h00;
    check("rhold_dr",   32'(dataReceived), 32'h0);
    check("rhold_ctrl", 32'(control),      32'h0);
    check("rhold_data", inputData,         32'h0);
    ov_cnt = 0;
    send_frame(8'h06, 32'h01020304);
    check("rhold_f_dr",   32'(dataReceived), 32'h1);
    check("rhold_f_ctrl", 32'(control),      32'h06);
    check("rhold_f_data", inputData,         32'h01020304);
    check("rhold_f_ov",   32'(ov_cnt),       32'h0);

`ifdef HOST_FRAME_CHECKSUM_EN
    release_frame();
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h09);
    check("chk_ok_dr",   32'(dataReceived), 32'h1);
    check("chk_ok_ctrl", 32'(control),      32'h01);
    check("chk_ok_data", inputData,         32'h12345678);
    release_frame();
    fe_cnt = 0;
    send_byte(8'hA5); send_byte(8'h07);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h00);
    check("chk_bad_fe",   32'(fe_cnt),       32'h1);
    check("chk_bad_dr",   32'(dataReceived), 32'h0);
    check("chk_bad_ctrl", 32'(control),      32'h01);
    check("chk_bad_data", inputData,         32'h12345678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
